// File: rtl/mmio_resp_if.sv
// Stage M data-memory port plus UART ready/valid pair seen by the MMIO responder.
// master = CPU/UART side driving requests; slave = mmio_resp.
interface mmio_resp_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;
  logic        inst_retired;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  modport master (
    output addr, wdata, we, re, inst_retired, uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  addr, wdata, we, re, inst_retired, uart_tx_ready, uart_rx_data, uart_rx_valid,
    output rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/mmio_resp.sv
// MMIO responder: UART TX FIFO, RX holding register, cycle/instret counters; 1-cycle registered rdata.
// TX pushes while full are dropped; RX is held off (ready=0) while the holding register is occupied.
module mmio_resp #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [3:0]  MMIO_BASE  = 4'h8
) (
  input  logic       clk,
  input  logic       reset,
  mmio_resp_if.slave io
);
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [31:0]   rdata_q, rdata_d;
  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   cyc_q, cyc_d, ins_q, ins_d;

  logic       sel, wr, rd, tx_full, push, pop, rx_pop, rx_acc, cnt_rst;
  logic [7:0] off;
  logic       unused_ok;

  assign unused_ok = ^{io.addr[27:8], io.wdata[31:8]};

  always_comb begin
    sel     = (io.addr[31:28] == MMIO_BASE);
    wr      = sel && (io.we != 4'b0);
    rd      = sel && io.re;
    off     = io.addr[7:0];
    tx_full = (cnt_q == FULL_CNT);
    // Full is judged before any same-cycle pop, so a push into a full FIFO is lost.
    push    = wr && (off == 8'h08) && io.we[0] && !tx_full;
    pop     = (cnt_q != '0) && io.uart_tx_ready;
    rx_pop  = rd && (off == 8'h04) && rx_full_q;
    rx_acc  = io.uart_rx_valid && !rx_full_q;
    cnt_rst = wr && (off == 8'h18);

    rdata_d = rdata_q;
    if (rd) begin
      unique case (off)
        8'h00:   rdata_d = {30'b0, rx_full_q, !tx_full};
        8'h04:   rdata_d = rx_full_q ? {24'b0, rx_byte_q} : 32'b0;
        8'h10:   rdata_d = cyc_q;
        8'h14:   rdata_d = ins_q;
        default: rdata_d = 32'b0;
      endcase
    end else if (io.re) begin
      rdata_d = 32'b0;
    end

    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_pop) begin
      rx_full_d = 1'b0;
    end else if (rx_acc) begin
      rx_full_d = 1'b1;
      rx_byte_d = io.uart_rx_data;
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = io.wdata[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    cyc_d = cnt_rst ? 32'b0 : cyc_q + 32'd1;
    ins_d = cnt_rst ? 32'b0 : ins_q + 32'(io.inst_retired);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q   <= '0;
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      cyc_q     <= '0;
      ins_q     <= '0;
    end else begin
      rdata_q   <= rdata_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

  assign io.rdata         = rdata_q;
  assign io.uart_tx_data  = mem_q[rd_ptr_q];
  assign io.uart_tx_valid = (cnt_q != '0);
  assign io.uart_rx_ready = !rx_full_q;
endmodule

// File: tb/tb_mmio_resp.sv
// Directed bench for mmio_resp: inputs change on negedge, outputs sampled on negedge.
module tb_mmio_resp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] d;

  mmio_resp_if io();

  mmio_resp #(.FIFO_DEPTH(8), .MMIO_BASE(4'h8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] data);
    io.addr = {4'h8, 20'h0, off};
    io.re   = 1'b1;
    @(negedge clk);
    io.re   = 1'b0;
    data    = io.rdata;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be);
    io.addr  = {4'h8, 20'h0, off};
    io.wdata = data;
    io.we    = be;
    @(negedge clk);
    io.we    = 4'b0;
  endtask

  initial begin
    io.addr = '0; io.wdata = '0; io.we = '0; io.re = 1'b0; io.inst_retired = 1'b0;
    io.uart_tx_ready = 1'b0; io.uart_rx_data = '0; io.uart_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", io.rdata, 32'h0);
    check_eq("rst_tx_valid", {31'b0, io.uart_tx_valid}, 32'h0);
    check_eq("rst_tx_data", {24'b0, io.uart_tx_data}, 32'h0);
    check_eq("rst_rx_ready", {31'b0, io.uart_rx_ready}, 32'h1);

    // CTRL read issued in cycle 0, CYCLE_CNT read in cycle 1.
    reset = 1'b1;
    io.addr = 32'h8000_0000; io.re = 1'b1;
    @(negedge clk);
    check_eq("ctrl_after_rst", io.rdata, 32'h1);
    io.addr = 32'h8000_0010;
    @(negedge clk);
    io.re = 1'b0;
    check_eq("cycle_after_rst", io.rdata, 32'h1);

    // Fill TX FIFO with ready low; ninth byte dropped.
    for (int i = 0; i < 8; i++) wr(8'h08, 32'h41 + i, 4'b0001);
    rd(8'h00, d);
    check_eq("ctrl_tx_full", d, 32'h0);
    wr(8'h08, 32'h49, 4'b0001);
    check_eq("tx_head", {24'b0, io.uart_tx_data}, 32'h41);
    io.uart_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain1_valid", {31'b0, io.uart_tx_valid}, 32'h1);
      check_eq("drain1_data", {24'b0, io.uart_tx_data}, 32'h41 + i);
      @(negedge clk);
    end
    check_eq("drain1_empty", {31'b0, io.uart_tx_valid}, 32'h0);
    io.uart_tx_ready = 1'b0;
    wr(8'h08, 32'h99, 4'b0010);
    check_eq("tx_we0_ignored", {31'b0, io.uart_tx_valid}, 32'h0);

    // Push into a full FIFO while a pop happens: dropped.
    for (int i = 0; i < 8; i++) wr(8'h08, 32'h61 + i, 4'b0001);
    io.uart_tx_ready = 1'b1;
    wr(8'h08, 32'h55, 4'b0001);
    io.uart_tx_ready = 1'b0;
    rd(8'h00, d);
    check_eq("ctrl_after_drop", d, 32'h1);
    wr(8'h08, 32'h56, 4'b0001);
    rd(8'h00, d);
    check_eq("ctrl_refull", d, 32'h0);
    io.uart_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain2_data", {24'b0, io.uart_tx_data}, (i == 7) ? 32'h56 : 32'h62 + i);
      @(negedge clk);
    end
    check_eq("drain2_empty", {31'b0, io.uart_tx_valid}, 32'h0);
    io.uart_tx_ready = 1'b0;

    // RX holding register; arrival during pop is refused.
    io.uart_rx_data = 8'hA5; io.uart_rx_valid = 1'b1;
    check_eq("rx_ready_before", {31'b0, io.uart_rx_ready}, 32'h1);
    @(negedge clk);
    io.uart_rx_data = 8'h5A;
    check_eq("rx_ready_full", {31'b0, io.uart_rx_ready}, 32'h0);
    rd(8'h00, d);
    check_eq("ctrl_rx_full", d, 32'h3);
    rd(8'h04, d);
    io.uart_rx_valid = 1'b0;
    check_eq("rx_pop_data", d, 32'hA5);
    check_eq("rx_ready_after_pop", {31'b0, io.uart_rx_ready}, 32'h1);
    rd(8'h04, d);
    check_eq("rx_empty_read", d, 32'h0);

    // Counters.
    for (int i = 0; i < 5; i++) begin
      io.inst_retired = 1'b1;
      @(negedge clk);
      io.inst_retired = 1'b0;
      @(negedge clk);
    end
    rd(8'h14, d);
    check_eq("instr_cnt5", d, 32'h5);
    io.inst_retired = 1'b1;
    wr(8'h18, 32'h0, 4'b1111);
    io.inst_retired = 1'b0;
    rd(8'h10, d);
    check_eq("cycle_cleared", d, 32'h0);
    rd(8'h14, d);
    check_eq("instr_cleared", d, 32'h0);
    rd(8'h10, d);
    check_eq("cycle_counting", d, 32'h2);
    @(negedge clk);
    check_eq("rdata_hold", io.rdata, 32'h2);
    rd(8'h0C, d);
    check_eq("unmapped_read", d, 32'h0);
    rd(8'h10, d);
    io.addr = 32'h1000_0010; io.re = 1'b1;
    @(negedge clk);
    io.re = 1'b0;
    check_eq("unselected_re", io.rdata, 32'h0);

    // Cycle counter wrap.
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    @(negedge clk);
    rd(8'h10, d);
    check_eq("cycle_wrap", d, 32'h0);

    // Asynchronous reset in the middle of traffic.
    wr(8'h08, 32'h77, 4'b0001);
    wr(8'h08, 32'h78, 4'b0001);
    io.uart_rx_data = 8'h33; io.uart_rx_valid = 1'b1;
    @(negedge clk);
    io.uart_rx_valid = 1'b0;
    check_eq("pre_rst_tx_valid", {31'b0, io.uart_tx_valid}, 32'h1);
    check_eq("pre_rst_rx_ready", {31'b0, io.uart_rx_ready}, 32'h0);
    rd(8'h14, d);
    io.inst_retired = 1'b0;
    rd(8'h10, d);
    check_eq("pre_rst_rdata_nz", {31'b0, (d != 32'h0)}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_tx_valid", {31'b0, io.uart_tx_valid}, 32'h0);
    check_eq("arst_tx_data", {24'b0, io.uart_tx_data}, 32'h0);
    check_eq("arst_rx_ready", {31'b0, io.uart_rx_ready}, 32'h1);
    check_eq("arst_rdata", io.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd(8'h00, d);
    check_eq("ctrl_after_arst", d, 32'h1);
    rd(8'h04, d);
    check_eq("rx_after_arst", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_resp.md
# mmio_resp

Memory-mapped I/O responder on the Stage M data-memory port of the Riscv151 pipeline. It decodes CPU loads and stores in the MMIO region and answers them with one-cycle registered read data, the same timing as the data cache. It provides:
- a UART transmit FIFO and a single-entry receive holding register, with ready/valid handshakes to the UART;
- free-running cycle and retired-instruction counters.

## Interface
Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2
- MMIO_BASE, 4'h8, value of addr[31:28] that selects this block

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- addr  input  32  Stage M byte address from ALU
- wdata  input  32  store data, already lane-aligned
- we  input  4  byte write enables (same encoding as DCache_WE)
- re  input  1  load strobe
- rdata  output  32  registered load data
- inst_retired  input  1  one-cycle pulse per retired instruction
- uart_tx_data  output  8  byte at the TX FIFO head
- uart_tx_valid  output  1  TX FIFO non-empty
- uart_tx_ready  input  1  UART accepts the byte
- uart_rx_data  input  8  received byte
- uart_rx_valid  input  1  received byte available
- uart_rx_ready  output  1  holding register empty

## Operation
- sel = (addr[31:28] == MMIO_BASE). A write is sel & (we != 0); a read is sel & re. Offset is addr[7:0]; addr[27:8] is ignored.
- Register map:
  - 0x00 CTRL (read-only): bit0 = !tx_full, bit1 = rx_full, bits 31:2 = 0.
  - 0x04 RX_DATA (read pops): if rx_full, returns {24'b0, rx_byte} and clears rx_full. If empty, returns 0 with no side effect.
  - 0x08 TX_DATA (write-only): if we[0] & !tx_full, pushes wdata[7:0]. A push while full is silently dropped, including when a pop happens in the same cycle (full is evaluated before the pop). Writes with we[0]=0 are ignored.
  - 0x10 CYCLE_CNT (read-only).
  - 0x14 INSTR_CNT (read-only).
  - 0x18 CNT_RST (write-only): any write clears both counters.
  - All other offsets and write-only registers read 0; writes to them are ignored.
- RX path:
  - uart_rx_ready = !rx_full.
  - When uart_rx_valid & uart_rx_ready at an edge, the byte is captured and rx_full is set.
  - If a pop and an arrival occur in the same cycle, the pop clears the register and the arrival is not accepted, because ready was 0 that cycle.
- TX FIFO:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits and a count of log2(FIFO_DEPTH)+1 bits.
  - uart_tx_valid = (count != 0); uart_tx_data = mem[rd_ptr].
  - Pop on uart_tx_valid & uart_tx_ready.
  - A simultaneous push and pop when not full leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - CYCLE_CNT increments every cycle.
  - INSTR_CNT increments on each cycle with inst_retired=1.
  - Both are 32 bits and wrap from 0xFFFFFFFF to 0.
  - A CNT_RST write takes priority over the increment: both counters read 0 after that edge.
- If re and a write occur in the same cycle, both are performed. rdata reflects pre-write state.

## Timing
- Reset (reset=0, asynchronous): rdata=0, rx_full=0, FIFO count and pointers 0, FIFO storage 0, both counters 0. Consequently uart_tx_valid=0, uart_tx_data=0, uart_rx_ready=1.
- Read latency is 1 cycle: a read presented in cycle N yields rdata in cycle N+1, sampled from state before edge N. For example, CYCLE_CNT returns the count of cycle N.
- rdata holds its value when no read is selected. An unselected re drives rdata to 0.
- TX: a push at edge N makes uart_tx_valid=1 in cycle N+1. Each ready&valid edge removes exactly one byte.
- RX: a byte captured at edge N is visible as CTRL.bit1=1 to a read issued in cycle N+1.
- Reset asserted mid-transfer discards FIFO contents and any held RX byte immediately. No partial state survives.

## Test plan
- Reset, then read CTRL and CYCLE_CNT back-to-back -> rdata=0x1, then 0x1 (cycle index of that read after reset release); uart_tx_valid=0, uart_rx_ready=1.
- With uart_tx_ready=0, write 0x41..0x49 to 0x08 (9 writes, depth 8) -> CTRL.bit0=0 after the 8th write; 9th byte dropped. Raise ready -> uart_tx_data sequence 0x41..0x48, then valid=0.
- With FIFO full and uart_tx_ready=1, push 0x55 -> byte dropped, count goes to 7. Next push 0x56 -> accepted; 0x56 appears last.
- Drive uart_rx_valid=1 with 0xA5 -> uart_rx_ready=0, CTRL=0x3. Read 0x04 -> rdata=0x000000A5, rx_ready=1 next cycle. Second read of 0x04 -> 0.
- Pulse inst_retired 5 times, read 0x14 -> 5. Write 0x18 while inst_retired=1 -> INSTR_CNT=0 and CYCLE_CNT=0 on the next read.
- Preload CYCLE_CNT to 0xFFFFFFFF via force; one cycle later read -> 0x00000000. Assert reset mid-TX -> uart_tx_valid drops to 0 without waiting for a clock edge.
